// File: rtl/dlfloat_dot_acc.sv
// dlfloat_dot_acc: DLFloat16 dot-product engine.
//
// Accepts VEC_LEN operand pairs over a valid/ready handshake, multiplies each pair,
// accumulates the products and presents the sum over a valid/ready output handshake.
// Format: {sign, exp[5:0] (bias 31), mant[8:0]} with hidden 1; exp 0 encodes zero.
//
// Parameters:
//   VEC_LEN  pairs per result (1..255)
//   CHAIN    0: accumulator cleared after each result, 1: running sum carried over
//   CNT_W    width of count, 2^CNT_W > VEC_LEN
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort: drops partial sum and pending product
//   in_valid   operand pair present      in_ready   pair accepted this cycle
//   a, b       DLFloat16 operands
//   out_valid  result present            out_ready  consumer takes result
//   result     accumulated sum           count      pairs accepted in current vector
module dlfloat_dot_acc #(
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned CHAIN   = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {StAcc, StDrain, StDone} state_e;

    state_e      state;
    logic [15:0] acc;
    logic [15:0] prod;
    logic        prod_vld;
    logic        accept;

    // in_ready is a registered flag that is only ever high in StAcc
    assign accept = in_valid & in_ready;
    assign result = acc;

    // ---------------------------------------------------------------- multiplier
    logic [9:0]  mul_ma, mul_mb;
    logic [19:0] mul_p;
    logic [8:0]  mul_mant;
    logic [8:0]  mul_esum;
    logic        mul_sign;
    logic [15:0] mul_res;

    always_comb begin
        mul_ma   = {1'b1, a[8:0]};
        mul_mb   = {1'b1, b[8:0]};
        mul_p    = mul_ma * mul_mb;
        mul_sign = a[15] ^ b[15];
        mul_mant = mul_p[19] ? mul_p[18:10] : mul_p[17:9];
        // Biased sum ea+eb (+1 when normalising); result exponent is this minus 31
        mul_esum = {3'b000, a[14:9]} + {3'b000, b[14:9]} + {8'd0, mul_p[19]};
        if (a[14:9] == 6'd0 || b[14:9] == 6'd0) begin
            mul_res = 16'h0000;
        end else if (mul_esum > 9'd93) begin
            mul_res = {mul_sign, 6'd62, 9'h1FF};
        end else if (mul_esum < 9'd32) begin
            mul_res = 16'h0000;
        end else begin
            mul_res = {mul_sign, 6'(mul_esum - 9'd31), mul_mant};
        end
    end

    logic unused_mul_lsbs;
    assign unused_mul_lsbs = ^mul_p[8:0];

    // ---------------------------------------------------------------- adder
    logic        add_swap;
    logic        big_s, small_s;
    logic [5:0]  big_e, small_e, add_sh;
    logic [9:0]  big_sig, small_sig;
    logic [10:0] add_sum;
    logic [9:0]  add_diff, add_norm;
    logic [3:0]  add_lz;
    logic [15:0] add_res;

    always_comb begin
        // Larger magnitude goes on the "big" side; it sets exponent and sign
        add_swap = (prod[14:9] > acc[14:9]) ||
                   ((prod[14:9] == acc[14:9]) && (prod[8:0] > acc[8:0]));
        big_s    = add_swap ? prod[15]   : acc[15];
        big_e    = add_swap ? prod[14:9] : acc[14:9];
        big_sig  = add_swap ? {1'b1, prod[8:0]} : {1'b1, acc[8:0]};
        small_s  = add_swap ? acc[15]    : prod[15];
        small_e  = add_swap ? acc[14:9]  : prod[14:9];
        add_sh   = big_e - small_e;
        small_sig = (add_sh >= 6'd11) ? 10'd0
                  : ((add_swap ? {1'b1, acc[8:0]} : {1'b1, prod[8:0]}) >> add_sh);
        add_sum  = {1'b0, big_sig} + {1'b0, small_sig};
        add_diff = big_sig - small_sig;
        add_lz   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (add_diff[i]) add_lz = 4'(9 - i);
        end
        add_norm = add_diff << add_lz;

        if (acc[14:9] == 6'd0) begin
            add_res = prod;
        end else if (prod[14:9] == 6'd0) begin
            add_res = acc;
        end else if (big_s == small_s) begin
            if (add_sum[10]) begin
                add_res = (big_e >= 6'd62) ? {big_s, 6'd62, 9'h1FF}
                                           : {big_s, big_e + 6'd1, add_sum[9:1]};
            end else begin
                add_res = {big_s, big_e, add_sum[8:0]};
            end
        end else if (add_diff == 10'd0) begin
            add_res = 16'h0000;
        end else if ({2'b00, add_lz} >= big_e) begin
            add_res = 16'h0000;
        end else begin
            add_res = {big_s, big_e - {2'b00, add_lz}, add_norm[8:0]};
        end
    end

    logic unused_add_msb;
    assign unused_add_msb = add_norm[9];

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StAcc;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= StAcc;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StAcc: begin
                    if (in_valid) begin
                        count <= count + CNT_W'(1);
                        if (count == LastCnt) begin
                            state    <= StDrain;
                            in_ready <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    state     <= StDone;
                    out_valid <= 1'b1;
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StAcc;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= StAcc;
                    count     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod     <= 16'h0000;
            prod_vld <= 1'b0;
            acc      <= 16'h0000;
        end else if (clr) begin
            prod     <= 16'h0000;
            prod_vld <= 1'b0;
            acc      <= 16'h0000;
        end else begin
            prod_vld <= accept;
            if (accept) prod <= mul_res;
            if (prod_vld) begin
                acc <= add_res;
            end else if (state == StDone && out_ready && CHAIN == 0) begin
                acc <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_dlfloat_dot_acc.sv
module tb_dlfloat_dot_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;

    logic        ir  [3];
    logic        ov  [3];
    logic [15:0] res [3];
    logic [7:0]  cnt [3];

    int          sel = 0;
    logic        s_ir, s_ov;
    logic [15:0] s_res;
    logic [7:0]  s_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dlfloat_dot_acc #(.VEC_LEN(4), .CHAIN(0), .CNT_W(8)) u_v4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
        .count(cnt[0])
    );
    dlfloat_dot_acc #(.VEC_LEN(2), .CHAIN(0), .CNT_W(8)) u_v2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
        .count(cnt[1])
    );
    dlfloat_dot_acc #(.VEC_LEN(2), .CHAIN(1), .CNT_W(8)) u_c2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
        .count(cnt[2])
    );

    always_comb begin
        s_ir  = ir[sel];
        s_ov  = ov[sel];
        s_res = res[sel];
        s_cnt = cnt[sel];
    end

    // ------------------------------------------------------------ reference model
    function automatic real pow2(input int e);
        real v = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) v = v * 2.0;
        else        for (int i = 0; i < -e; i++) v = v / 2.0;
        return v;
    endfunction

    function automatic real to_real(input logic [15:0] x);
        real v;
        if (x[14:9] == 6'd0) return 0.0;
        v = (512.0 + real'(x[8:0])) / 512.0 * pow2(int'(x[14:9]) - 31);
        return x[15] ? -v : v;
    endfunction

    // Truncate an exact value into the format, with saturation and flush-to-zero
    function automatic logic [15:0] from_real(input real x);
        real  v;
        int   e = 31;
        int   m;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        v = s ? -x : x;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        if (e > 62) return {s, 6'd62, 9'h1FF};
        if (e < 1)  return 16'h0000;
        m = $rtoi(v * 512.0) - 512;
        return {s, 6'(e), 9'(m)};
    endfunction

    function automatic logic [15:0] mul_model(input logic [15:0] x, input logic [15:0] y);
        if (x[14:9] == 6'd0 || y[14:9] == 6'd0) return 16'h0000;
        return from_real(to_real(x) * to_real(y));
    endfunction

    // Smaller operand is truncated onto the larger operand's 10-bit significand grid
    function automatic logic [15:0] add_model(input logic [15:0] x, input logic [15:0] y);
        real rx, ry, big, sm, step, smt;
        int  be;
        if (x[14:9] == 6'd0) return y;
        if (y[14:9] == 6'd0) return x;
        rx = to_real(x);
        ry = to_real(y);
        if ((rx < 0.0 ? -rx : rx) >= (ry < 0.0 ? -ry : ry)) begin
            big = rx; sm = ry; be = int'(x[14:9]);
        end else begin
            big = ry; sm = rx; be = int'(y[14:9]);
        end
        step = pow2(be - 40);
        smt  = real'($rtoi((sm < 0.0 ? -sm : sm) / step)) * step;
        if (sm < 0.0) smt = -smt;
        return from_real(big + smt);
    endfunction

    function automatic logic [15:0] rand_op();
        int unsigned r = $urandom_range(0, 19);
        logic [5:0]  e;
        logic [8:0]  m = 9'($urandom_range(0, 511));
        logic        s = 1'($urandom_range(0, 1));
        if (r == 0)      e = 6'd0;
        else if (r == 1) e = 6'($urandom_range(58, 62));
        else if (r == 2) e = 6'($urandom_range(1, 6));
        else             e = 6'($urandom_range(27, 35));
        return {s, e, m};
    endfunction

    // ------------------------------------------------------------ stimulus helpers
    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [15:0] pa, input logic [15:0] pb);
        int n = 0;
        a = pa; b = pb; in_valid = 1'b1;
        while (!s_ir && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) $display("FAIL push_timeout in_ready got %b want 1", s_ir);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(output logic [15:0] r);
        int n = 0;
        out_ready = 1'b1;
        while (!s_ov && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) $display("FAIL result_timeout out_valid got %b want 1", s_ov);
        else passed++;
        r = s_res;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        sel = 0;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (s_cnt !== 8'd0) $display("FAIL reset_count_held got %0d want 0", s_cnt); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (s_ir !== 1'b1) $display("FAIL reset_in_ready got %b want 1", s_ir); else passed++;
        total++; if (s_ov !== 1'b0) $display("FAIL reset_out_valid got %b want 0", s_ov); else passed++;
        total++; if (s_res !== 16'h0000) $display("FAIL reset_result got %h want 0000", s_res); else passed++;
        total++; if (s_cnt !== 8'd0) $display("FAIL reset_count got %0d want 0", s_cnt); else passed++;
    endtask

    task automatic test_basic();
        sel = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push(16'h3E00, 16'h3E00);
        // One cycle after the last accept: DRAIN
        total++; if (s_ov !== 1'b0) $display("FAIL basic_drain_valid got %b want 0", s_ov); else passed++;
        total++; if (s_ir !== 1'b0) $display("FAIL basic_drain_ready got %b want 0", s_ir); else passed++;
        @(negedge clk);
        total++; if (s_ov !== 1'b1) $display("FAIL basic_latency_valid got %b want 1", s_ov); else passed++;
        total++; if (s_res !== 16'h4200) $display("FAIL basic_result got %h want 4200", s_res); else passed++;
        total++; if (s_cnt !== 8'd4) $display("FAIL basic_count got %0d want 4", s_cnt); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (s_ov !== 1'b0) $display("FAIL basic_after_valid got %b want 0", s_ov); else passed++;
        total++; if (s_ir !== 1'b1) $display("FAIL basic_after_ready got %b want 1", s_ir); else passed++;
        total++; if (s_cnt !== 8'd0) $display("FAIL basic_after_count got %0d want 0", s_cnt); else passed++;
    endtask

    task automatic test_cancel_zero();
        logic [15:0] r;
        sel = 1;
        do_reset();
        push(16'h4000, 16'h3F00); push(16'h3E00, 16'hC100);
        get_result(r);
        total++; if (r !== 16'h0000) $display("FAIL cancel_result got %h want 0000", r); else passed++;
        push(16'h3E00, 16'h3E00); push(16'h01FF, 16'h4000);
        get_result(r);
        total++; if (r !== 16'h3E00) $display("FAIL zero_mant_operand got %h want 3E00", r); else passed++;
        push(16'h0000, 16'h7DFF); push(16'h3F00, 16'h4000);
        get_result(r);
        total++; if (r !== 16'h4100) $display("FAIL zero_operand got %h want 4100", r); else passed++;
    endtask

    task automatic test_saturation();
        logic [15:0] r;
        sel = 1;
        do_reset();
        push(16'h7DFF, 16'h7DFF); push(16'h7DFF, 16'h7DFF);
        get_result(r);
        total++; if (r !== 16'h7DFF) $display("FAIL sat_pos got %h want 7DFF", r); else passed++;
        push(16'hFDFF, 16'h7DFF); push(16'hFDFF, 16'h7DFF);
        get_result(r);
        total++; if (r !== 16'hFDFF) $display("FAIL sat_neg got %h want FDFF", r); else passed++;
        push(16'h3C00, 16'h3C00); push(16'h0200, 16'h0200);
        get_result(r);
        total++; if (r !== 16'h3A00) $display("FAIL underflow got %h want 3A00", r); else passed++;
    endtask

    task automatic test_backpressure();
        logic [15:0] r;
        sel = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push(16'h3E00, 16'h3E00);
        @(negedge clk);
        in_valid = 1'b1; a = 16'h4000; b = 16'h4000;
        for (int i = 0; i < 10; i++) begin
            total++; if (s_ov !== 1'b1) $display("FAIL bp_valid got %b want 1", s_ov); else passed++;
            total++; if (s_res !== 16'h4200) $display("FAIL bp_result got %h want 4200", s_res); else passed++;
            total++; if (s_ir !== 1'b0) $display("FAIL bp_in_ready got %b want 0", s_ir); else passed++;
            total++; if (s_cnt !== 8'd4) $display("FAIL bp_count got %0d want 4", s_cnt); else passed++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (s_ov !== 1'b0) $display("FAIL bp_release_valid got %b want 0", s_ov); else passed++;
        total++; if (s_ir !== 1'b1) $display("FAIL bp_release_ready got %b want 1", s_ir); else passed++;
        total++; if (s_cnt !== 8'd0) $display("FAIL bp_release_count got %0d want 0", s_cnt); else passed++;
        for (int i = 0; i < 4; i++) push(16'h3E00, 16'h3E00);
        get_result(r);
        total++; if (r !== 16'h4200) $display("FAIL bp_next_vector got %h want 4200", r); else passed++;
    endtask

    task automatic test_chain();
        logic [15:0] r;
        sel = 2;
        do_reset();
        push(16'h3E00, 16'h3E00); push(16'h3E00, 16'h3E00);
        get_result(r);
        total++; if (r !== 16'h4000) $display("FAIL chain_first got %h want 4000", r); else passed++;
        push(16'h3E00, 16'h3E00); push(16'h3E00, 16'h3E00);
        get_result(r);
        total++; if (r !== 16'h4200) $display("FAIL chain_second got %h want 4200", r); else passed++;
    endtask

    task automatic test_clr_and_reset();
        logic [15:0] r;
        sel = 0;
        do_reset();
        for (int i = 0; i < 3; i++) push(16'h3E00, 16'h3E00);
        clr = 1'b1; in_valid = 1'b1; a = 16'h3E00; b = 16'h3E00;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        total++; if (s_cnt !== 8'd0) $display("FAIL clr_count got %0d want 0", s_cnt); else passed++;
        total++; if (s_ov !== 1'b0) $display("FAIL clr_valid got %b want 0", s_ov); else passed++;
        total++; if (s_ir !== 1'b1) $display("FAIL clr_ready got %b want 1", s_ir); else passed++;
        for (int i = 0; i < 4; i++) push(16'h3E00, 16'h3E00);
        get_result(r);
        total++; if (r !== 16'h4200) $display("FAIL clr_fresh got %h want 4200", r); else passed++;
        // clr beats out_ready in DONE: result is lost, acc cleared
        for (int i = 0; i < 4; i++) push(16'h3E00, 16'h3E00);
        @(negedge clk);
        clr = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; out_ready = 1'b0;
        total++; if (s_ov !== 1'b0) $display("FAIL clr_done_valid got %b want 0", s_ov); else passed++;
        total++; if (s_res !== 16'h0000) $display("FAIL clr_done_result got %h want 0000", s_res); else passed++;
        // Asynchronous reset mid-vector
        push(16'h3E00, 16'h3E00); push(16'h3E00, 16'h3E00);
        #2 rst_n = 1'b0;
        #1;
        total++; if (s_cnt !== 8'd0) $display("FAIL rst_count got %0d want 0", s_cnt); else passed++;
        total++; if (s_ov !== 1'b0) $display("FAIL rst_valid got %b want 0", s_ov); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push(16'h3E00, 16'h3E00);
        get_result(r);
        total++; if (r !== 16'h4200) $display("FAIL rst_fresh got %h want 4200", r); else passed++;
    endtask

    task automatic test_random(input int which, input int vlen, input bit chain, input int nvec);
        logic [15:0] expq[$];
        logic [15:0] macc = 16'h0000;
        logic [15:0] want;
        int          mcnt = 0;
        int          got = 0;
        int          cycles = 0;
        sel = which;
        do_reset();
        while (got < nvec && cycles < 5000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = rand_op();
            b         = rand_op();
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && s_ir) begin
                macc = add_model(macc, mul_model(a, b));
                mcnt++;
                if (mcnt == vlen) begin
                    expq.push_back(macc);
                    mcnt = 0;
                    if (!chain) macc = 16'h0000;
                end
            end
            if (s_ov && out_ready) begin
                want = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
                total++;
                if (s_res !== want)
                    $display("FAIL rand%0d_result vec %0d got %h want %h", which, got, s_res, want);
                else passed++;
                total++;
                if (s_cnt !== 8'(vlen))
                    $display("FAIL rand%0d_count got %0d want %0d", which, s_cnt, vlen);
                else passed++;
                got++;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (got < nvec) $display("FAIL rand%0d_timeout results got %0d want %0d", which, got, nvec);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cancel_zero();
        test_saturation();
        test_backpressure();
        test_chain();
        test_clr_and_reset();
        test_random(0, 4, 1'b0, 25);
        test_random(1, 2, 1'b0, 25);
        test_random(2, 2, 1'b1, 25);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
